// File: rtl/ramrom_bus_initiator.sv
// ramrom_bus_initiator: turns valid/ready word requests into 6502-style bus cycles
// with free-running PHI2 and optional read-back of writes to the $BFFE/$BFFF latches.
`default_nettype none

module ramrom_bus_initiator #(
   parameter int PHASE_DIV     = 4,
   parameter bit VERIFY_WRITES = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_rw_i,
   input  logic [15:0] req_addr_i,
   input  logic [3:0]  req_data_i,
   output logic        rsp_valid_o,
   output logic [3:0]  rsp_data_o,
   output logic        rsp_err_o,
   output logic [15:0] addr_o,
   output logic        rw_o,
   output logic        phi2_o,
   output logic [3:0]  data_out_o,
   output logic        data_oe_o,
   input  logic [3:0]  data_in_i
);

   localparam int            CW       = $clog2(2 * PHASE_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(2 * PHASE_DIV - 1);
   localparam logic [CW-1:0] CNT_HIGH = CW'(PHASE_DIV);
   localparam logic [CW-1:0] CNT_OE   = CW'(PHASE_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_VERIFY, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          phi2_q, phi2_d;
   logic [15:0]   addr_q, addr_d;
   logic          rw_q, rw_d;
   logic [3:0]    data_out_q, data_out_d;
   logic          data_oe_q, data_oe_d;
   logic          cap_rw_q, cap_rw_d;
   logic [15:0]   cap_addr_q, cap_addr_d;
   logic [3:0]    cap_data_q, cap_data_d;
   logic [3:0]    rsp_data_q, rsp_data_d;
   logic          rsp_err_q, rsp_err_d;
   logic          w_boundary, w_hold, w_verify;

   assign w_boundary = (cnt_q == CNT_LAST);
   // The clock after a write's PHI2 falls: data, RW and address are still held.
   assign w_hold     = data_oe_q && (state_q != S_ACCESS);
   assign w_verify   = VERIFY_WRITES && ((cap_addr_q == 16'hBFFF) || (cap_addr_q == 16'hBFFE));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      data_out_d = data_out_q;
      cap_rw_d   = cap_rw_q;
      cap_addr_d = cap_addr_q;
      cap_data_d = cap_data_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      cnt_d      = w_boundary ? '0 : cnt_q + CW'(1);
      phi2_d     = (cnt_d >= CNT_HIGH);
      data_oe_d  = (state_q == S_ACCESS) && !cap_rw_q && (cnt_q >= CNT_OE);

      if (w_hold) begin
         rw_d = 1'b1;
         if (state_q != S_VERIFY) addr_d = 16'hFFFF;
      end

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               cap_rw_d   = req_rw_i;
               cap_addr_d = req_addr_i;
               cap_data_d = req_data_i;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_boundary) begin
               addr_d  = cap_addr_q;
               rw_d    = cap_rw_q;
               if (!cap_rw_q) data_out_d = cap_data_q;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (w_boundary) begin
               if (cap_rw_q) begin
                  rsp_data_d = data_in_i;
                  rsp_err_d  = 1'b0;
                  addr_d     = 16'hFFFF;
                  rw_d       = 1'b1;
                  state_d    = S_RESP;
               end else if (w_verify) begin
                  state_d = S_VERIFY;
               end else begin
                  rsp_data_d = 4'h0;
                  rsp_err_d  = 1'b0;
                  state_d    = S_RESP;
               end
            end
         end
         S_VERIFY: begin
            if (w_boundary) begin
               rsp_data_d = data_in_i;
               rsp_err_d  = (data_in_i != cap_data_q);
               addr_d     = 16'hFFFF;
               rw_d       = 1'b1;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         phi2_q     <= 1'b0;
         addr_q     <= 16'hFFFF;
         rw_q       <= 1'b1;
         data_out_q <= 4'h0;
         data_oe_q  <= 1'b0;
         cap_rw_q   <= 1'b1;
         cap_addr_q <= 16'hFFFF;
         cap_data_q <= 4'h0;
         rsp_data_q <= 4'h0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         phi2_q     <= phi2_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         data_out_q <= data_out_d;
         data_oe_q  <= data_oe_d;
         cap_rw_q   <= cap_rw_d;
         cap_addr_q <= cap_addr_d;
         cap_data_q <= cap_data_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;
   assign addr_o      = addr_q;
   assign rw_o        = rw_q;
   assign phi2_o      = phi2_q;
   assign data_out_o  = data_out_q;
   assign data_oe_o   = data_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_ramrom_bus_initiator.sv
// Bench for ramrom_bus_initiator: directed scenarios plus randomized requests
// checked against a transaction-level memory model.
`default_nettype none

module tb_ramrom_bus_initiator;

   localparam int TP = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_valid2 = 1'b0;
   logic        req_rw = 1'b1;
   logic [15:0] req_addr = 16'h0000;
   logic [3:0]  req_data = 4'h0;
   logic [3:0]  data_in;
   logic        req_ready, rsp_valid, rsp_err, rw, phi2, data_oe;
   logic [3:0]  rsp_data, data_out;
   logic [15:0] addr;
   logic        req_ready2, rsp_valid2, rsp_err2, rw2, phi2_2, data_oe2;
   logic [3:0]  rsp_data2, data_out2;
   logic [15:0] addr2;

   int n_checks = 0;
   int n_fail = 0;
   int ecnt;
   logic [3:0] mem [0:65535];
   logic [3:0] ref_mem [0:65535];
   logic [3:0] rd_mask = 4'h0;
   logic [15:0] m_addr_prev = 16'hFFFF;
   logic        m_phi2_prev = 1'b0;

   always #5 clk = ~clk;

   ramrom_bus_initiator #(.PHASE_DIV(TP), .VERIFY_WRITES(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_rw_i(req_rw), .req_addr_i(req_addr), .req_data_i(req_data),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
      .addr_o(addr), .rw_o(rw), .phi2_o(phi2), .data_out_o(data_out),
      .data_oe_o(data_oe), .data_in_i(data_in));

   ramrom_bus_initiator #(.PHASE_DIV(TP), .VERIFY_WRITES(1'b0)) dut_nv (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid2), .req_ready_o(req_ready2),
      .req_rw_i(req_rw), .req_addr_i(req_addr), .req_data_i(req_data),
      .rsp_valid_o(rsp_valid2), .rsp_data_o(rsp_data2), .rsp_err_o(rsp_err2),
      .addr_o(addr2), .rw_o(rw2), .phi2_o(phi2_2), .data_out_o(data_out2),
      .data_oe_o(data_oe2), .data_in_i(data_in));

   // Bus responder: a 4-bit memory that can corrupt reads with rd_mask.
   assign data_in = rw ? (mem[addr] ^ rd_mask) : 4'h0;
   always @(posedge clk) begin
      if (rst_n && phi2 && data_oe && !rw) mem[addr] <= data_out;
   end

   // Clocks since reset release; equals the initiator's phase position mod 2*TP.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecnt <= 0;
      else        ecnt <= ecnt + 1;
   end

   // Bus protocol watch: no drive while reading, no address change while PHI2 high.
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         n_checks++;
         if (data_oe && rw) begin
            n_fail++;
            $display("FAIL bus_oe_rw: data_oe=%b while rw=%b, required data_oe=0", data_oe, rw);
         end
         n_checks++;
         if (phi2 && m_phi2_prev && addr != m_addr_prev) begin
            n_fail++;
            $display("FAIL bus_addr_phi2: addr %h -> %h while phi2 high, required stable", m_addr_prev, addr);
         end
      end
      m_addr_prev <= addr;
      m_phi2_prev <= phi2;
   end

   // Transaction-level reference: what the response must be for one request.
   task automatic model(input bit rwi, input logic [15:0] a, input logic [3:0] d,
                        input logic [3:0] mask, output logic [3:0] ed, output logic ee,
                        output bit ev);
      ev = 1'b0;
      ee = 1'b0;
      if (rwi) begin
         ed = ref_mem[a] ^ mask;
      end else begin
         ref_mem[a] = d;
         ev = (a == 16'hBFFF) || (a == 16'hBFFE);
         ed = ev ? (d ^ mask) : 4'h0;
         ee = ev && (mask != 4'h0);
      end
   endtask

   function automatic int exp_latency(input int c, input bit ev);
      return ((2*TP - 1 - c + 2*TP - 1) % (2*TP)) + 1 + 2*TP + (ev ? 2*TP : 0);
   endfunction

   // Drives one request on the verifying instance; called just after a clock edge.
   task automatic issue(input bit rwi, input logic [15:0] a, input logic [3:0] d,
                        output logic [3:0] rd, output logic re, output int lat,
                        output int n_addr, output int n_oe, output int c);
      int g;
      req_rw = rwi; req_addr = a; req_data = d; req_valid = 1'b1;
      g = 0;
      while (!req_ready && g < 100) begin @(posedge clk); #1; g++; end
      c = ecnt % (2*TP);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; n_addr = 0; n_oe = 0;
      forever begin
         if (addr == a) n_addr++;
         if (data_oe) n_oe++;
         if (rsp_valid || lat >= 100) break;
         @(posedge clk); #1;
         lat++;
      end
      rd = rsp_data;
      re = rsp_err;
      n_checks++;
      if (lat >= 100) begin
         n_fail++;
         $display("FAIL rsp_timeout: no rsp_valid after %0d clocks, required within 100", lat);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks += 9;
      if (addr !== 16'hFFFF) begin n_fail++; $display("FAIL reset_addr: got %h, required FFFF", addr); end
      if (rw !== 1'b1)       begin n_fail++; $display("FAIL reset_rw: got %b, required 1", rw); end
      if (phi2 !== 1'b0)     begin n_fail++; $display("FAIL reset_phi2: got %b, required 0", phi2); end
      if (data_out !== 4'h0) begin n_fail++; $display("FAIL reset_dout: got %h, required 0", data_out); end
      if (data_oe !== 1'b0)  begin n_fail++; $display("FAIL reset_oe: got %b, required 0", data_oe); end
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", req_ready); end
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rspv: got %b, required 0", rsp_valid); end
      if (rsp_data !== 4'h0) begin n_fail++; $display("FAIL reset_rspd: got %h, required 0", rsp_data); end
      if (rsp_err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b, required 0", rsp_err); end
      rst_n = 1'b1;
      for (int k = 1; k <= 4*TP; k++) begin
         @(posedge clk); #1;
         n_checks += 2;
         if (phi2 !== ((k % (2*TP)) >= TP)) begin
            n_fail++; $display("FAIL phi2_period: clock %0d got %b, required %b", k, phi2, (k % (2*TP)) >= TP);
         end
         if (addr !== 16'hFFFF || rw !== 1'b1) begin
            n_fail++; $display("FAIL idle_bus: clock %0d addr %h rw %b, required FFFF 1", k, addr, rw);
         end
      end
   endtask

   task automatic run_directed(input string name, input bit rwi, input logic [15:0] a,
                               input logic [3:0] d, input logic [3:0] mask,
                               input int exp_naddr, input int exp_noe);
      logic [3:0] rd, ed; logic re, ee; bit ev; int lat, na, no, c;
      rd_mask = mask;
      model(rwi, a, d, mask, ed, ee, ev);
      issue(rwi, a, d, rd, re, lat, na, no, c);
      rd_mask = 4'h0;
      n_checks += 5;
      if (rd !== ed) begin n_fail++; $display("FAIL %s data: got %h, required %h", name, rd, ed); end
      if (re !== ee) begin n_fail++; $display("FAIL %s err: got %b, required %b", name, re, ee); end
      if (lat != exp_latency(c, ev)) begin
         n_fail++; $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_latency(c, ev));
      end
      if (na != exp_naddr) begin n_fail++; $display("FAIL %s addr_clocks: got %0d, required %0d", name, na, exp_naddr); end
      if (no != exp_noe) begin n_fail++; $display("FAIL %s oe_clocks: got %0d, required %0d", name, no, exp_noe); end
   endtask

   task automatic test_read();
      mem[16'hBFFD] = 4'hC;
      ref_mem[16'hBFFD] = 4'hC;
      run_directed("read_bffd", 1'b1, 16'hBFFD, 4'h0, 4'h0, 2*TP, 0);
   endtask

   task automatic test_verify();
      run_directed("verify_ok", 1'b0, 16'hBFFF, 4'h5, 4'h0, 4*TP, TP + 1);
      run_directed("verify_err", 1'b0, 16'hBFFE, 4'h3, 4'h2, 4*TP, TP + 1);
      run_directed("plain_write", 1'b0, 16'h0B00, 4'hA, 4'h0, 2*TP + 1, TP + 1);
   endtask

   task automatic test_no_verify();
      int lat, na, c;
      req_rw = 1'b0; req_addr = 16'hBFFF; req_data = 4'h7; req_valid2 = 1'b1;
      c = ecnt % (2*TP);
      @(posedge clk); #1;
      req_valid2 = 1'b0;
      lat = 0; na = 0;
      forever begin
         if (addr2 == 16'hBFFF) na++;
         if (rsp_valid2 || lat >= 100) break;
         @(posedge clk); #1;
         lat++;
      end
      n_checks += 4;
      if (lat != exp_latency(c, 1'b0)) begin
         n_fail++; $display("FAIL nv_latency: got %0d, required %0d", lat, exp_latency(c, 1'b0));
      end
      if (na != 2*TP + 1) begin n_fail++; $display("FAIL nv_addr_clocks: got %0d, required %0d", na, 2*TP + 1); end
      if (rsp_data2 !== 4'h0) begin n_fail++; $display("FAIL nv_data: got %h, required 0", rsp_data2); end
      if (rsp_err2 !== 1'b0) begin n_fail++; $display("FAIL nv_err: got %b, required 0", rsp_err2); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ed1, ed2; logic ee1, ee2; bit ev; int g;
      model(1'b1, 16'hBFFD, 4'h0, 4'h0, ed1, ee1, ev);
      model(1'b1, 16'h0B00, 4'h0, 4'h0, ed2, ee2, ev);
      req_rw = 1'b1; req_addr = 16'hBFFD; req_valid = 1'b1;
      g = 0;
      while (!rsp_valid && g < 100) begin @(posedge clk); #1; g++; end
      n_checks += 3;
      if (rsp_data !== ed1) begin n_fail++; $display("FAIL b2b_first: got %h, required %h", rsp_data, ed1); end
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_resp: got %b, required 0", req_ready); end
      req_addr = 16'h0B00;
      @(posedge clk); #1;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after: got %b, required 1", req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: ready got %b, required 0", req_ready); end
      g = 0;
      while (!rsp_valid && g < 100) begin @(posedge clk); #1; g++; end
      n_checks++;
      if (rsp_data !== ed2 || g >= 100) begin
         n_fail++; $display("FAIL b2b_second: got %h, required %h", rsp_data, ed2);
      end
   endtask

   task automatic test_random();
      logic [15:0] pool [4];
      logic [3:0] rd, ed, d, mask; logic re, ee; bit ev, rwi; int lat, na, no, c;
      logic [15:0] a;
      pool[0] = 16'hBFFF; pool[1] = 16'hBFFE; pool[2] = 16'hBFFD; pool[3] = 16'h1000;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 9)) begin @(posedge clk); #1; end
         rwi  = 1'($urandom_range(0, 1));
         a    = pool[$urandom_range(0, 3)];
         if (a == 16'h1000) a = a + 16'($urandom_range(0, 7));
         d    = 4'($urandom);
         mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         rd_mask = mask;
         model(rwi, a, d, mask, ed, ee, ev);
         issue(rwi, a, d, rd, re, lat, na, no, c);
         rd_mask = 4'h0;
         n_checks += 3;
         if (rd !== ed) begin n_fail++; $display("FAIL rand%0d data: rw %b addr %h got %h, required %h", i, rwi, a, rd, ed); end
         if (re !== ee) begin n_fail++; $display("FAIL rand%0d err: got %b, required %b", i, re, ee); end
         if (lat != exp_latency(c, ev)) begin
            n_fail++; $display("FAIL rand%0d latency: got %0d, required %0d", i, lat, exp_latency(c, ev));
         end
      end
   endtask

   task automatic test_reset_midop();
      int g, pulses;
      req_rw = 1'b0; req_addr = 16'h0C00; req_data = 4'h9; req_valid = 1'b1;
      g = 0;
      while (!data_oe && g < 100) begin
         @(posedge clk); #1; g++;
         if (!req_ready) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks += 2;
      if (g >= 100) begin n_fail++; $display("FAIL midop_reach: data_oe not seen in %0d clocks", g); end
      if (addr !== 16'hFFFF || rw !== 1'b1 || data_oe !== 1'b0 || phi2 !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_async: addr %h rw %b oe %b phi2 %b ready %b, required FFFF 1 0 0 1",
                  addr, rw, data_oe, phi2, req_ready);
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 6*TP; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin n_fail++; $display("FAIL midop_no_rsp: got %0d rsp_valid clocks, required 0", pulses); end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 4'h0;
         ref_mem[i] = 4'h0;
      end
      test_reset();
      test_read();
      test_verify();
      test_no_verify();
      test_back_to_back();
      test_random();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ramrom_bus_initiator.md
# ramrom_bus_initiator

Test-side 6502 bus-cycle initiator for the Atom RAM/ROM-box CPLD. It turns single-word requests on a valid/ready interface into 6502-style bus cycles (Addr, RW, PHI2, 4-bit data), with free-running PHI2 generation from a fast system clock. It can optionally verify writes to the control latches at $BFFF (rom select) and $BFFE (switch latch) with an automatic read-back. It sits in the bench or FPGA harness as the master that drives the RAM/ROM decoder's bus.

## Interface
- PhaseDiv, 4: Clk cycles per PHI2 half-phase; legal range 2..15; one bus cycle = 2*PhaseDiv clocks.
- VerifyWrites, 1: when 1, a write to $BFFF or $BFFE is followed by a read-back cycle to the same address.
- Clk  in  1  system clock; all state changes on rising edge.
- NReset  in  1  asynchronous active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  initiator can accept a request.
- ReqRW  in  1  1 = read, 0 = write.
- ReqAddr  in  16  target address.
- ReqData  in  4  write data; ignored for reads.
- RspValid  out  1  one-clock pulse: request complete.
- RspData  out  4  read data, or read-back data for a verified write; 0 for an unverified write.
- RspErr  out  1  valid with RspValid; 1 = verify mismatch.
- Addr  out  16  bus address.
- RW  out  1  bus read/write.
- PHI2  out  1  bus clock.
- DataOut  out  4  write data to bus.
- DataOE  out  1  DataOut drive enable.
- DataIn  in  4  read data from bus.

## Operation
- Phase counter Cnt runs 0..2*PhaseDiv-1 and wraps.
  - PHI2 = (Cnt >= PhaseDiv), registered.
  - A bus-cycle boundary is the clock on which Cnt becomes 0.
- Idle bus cycles: Addr = $FFFF, RW = 1, DataOE = 0.
- FSM states:
  - IDLE: ReqReady = 1. ReqValid & ReqReady captures ReqRW/ReqAddr/ReqData and goes to WAIT.
  - WAIT: wait for the next boundary. At the boundary, drive Addr and RW and go to ACCESS.
  - ACCESS: one full bus cycle.
    - Write: DataOut = captured data. DataOE rises with PHI2 and falls one clock after PHI2 falls (hold).
    - Read: DataIn is sampled on the last clock of the PHI2-high phase (Cnt = 2*PhaseDiv-1).
    - At the next boundary: if a write, VerifyWrites = 1 and Addr is $BFFF or $BFFE, go to VERIFY with RW = 1 on the same address. Otherwise go to RESP.
  - VERIFY: one read cycle, sampled as for a read. At the next boundary go to RESP.
  - RESP: RspValid = 1 for exactly one clock, then back to IDLE. The bus returns to idle values at that boundary.
- RspErr = 1 only in VERIFY outcomes where the sampled data ≠ the written data. In all other cases RspErr = 0.
- ReqReady is 0 from the clock after acceptance through the RspValid clock. A ReqValid during RESP is not accepted; it is accepted on the following clock.
- Addr and RW change only at boundaries (PHI2 low), never while PHI2 is high.

## Timing
- Reset values: Cnt = 0, PHI2 = 0, Addr = $FFFF, RW = 1, DataOut = 0, DataOE = 0, ReqReady = 1, RspValid = 0, RspData = 0, RspErr = 0, FSM = IDLE.
- Reset asserted mid-operation aborts immediately. No RspValid is produced. PHI2 may be truncated.
- Acceptance to RspValid latency:
  - (clocks to next boundary) + 2*PhaseDiv for a plain access.
  - Add 2*PhaseDiv for a verified write.
  - Minimum with PhaseDiv = 4: 9 clocks plain, 17 clocks verified.
- DataOE is never high while RW = 1.

## Test plan
- Reset: hold NReset low, then release. Check all reset values; PHI2 toggles every 4 clocks (PhaseDiv = 4); idle Addr = $FFFF.
- Read $BFFD with responder driving DataIn = 4'hC during PHI2 high → one RspValid, RspData = 4'hC, RspErr = 0; Addr stable for a full 8-clock cycle.
- Write $BFFF data 4'h5, responder latches it and reads back 4'h5 → write cycle then read cycle at $BFFF; DataOE high only in the write cycle's PHI2-high phase + 1 clock; RspData = 4'h5, RspErr = 0.
- Write $BFFE data 4'h3, responder returns 4'h1 on read-back → RspErr = 1, RspData = 4'h1.
- Write $0B00 data 4'hA → single bus cycle, no VERIFY, RspData = 0, RspErr = 0. Repeat with VerifyWrites = 0 at $BFFF → no read-back.
- Back-to-back: hold ReqValid high with two requests → second accepted the clock after RspValid. Assert NReset during ACCESS → no RspValid; bus returns to idle values asynchronously.
